// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART receive types, default oversampling ratio and a
//            2-of-3 majority helper.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int UART_OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx_sync
// Purpose  : SYNC_STAGES-deep metastability synchroniser for the serial line,
//            resetting to the idle (high) level.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_async.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx_async
// Purpose  : Oversampling UART receiver with a holding register and
//            ready/parity/framing/overflow flags. Define
//            UART_RX_GLITCH_FILTER_EN for 2-of-3 majority sampling.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_async
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = UART_OVERSAMPLE_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_pulse,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  output logic [7:0] rx_byte,
  output logic       rx_rdy,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow
);

  localparam int               CNT_W    = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

  logic rx_s;
  logic samp;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

`ifdef UART_RX_GLITCH_FILTER_EN
  // Vote window ends on the decision tick so frame timing matches the plain build.
  logic [1:0] hist_q;
  logic [1:0] hist_d;

  always_comb begin
    hist_d = hist_q;
    if (baud_pulse) begin
      hist_d = {hist_q[0], rx_s};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign samp = maj3(hist_q[1], hist_q[0], rx_s);
`else
  assign samp = rx_s;
`endif

  rx_state_e        state_q,       state_d;
  logic [CNT_W-1:0] samp_cnt_q,    samp_cnt_d;
  logic [2:0]       bit_cnt_q,     bit_cnt_d;
  logic [7:0]       shift_q,       shift_d;
  logic             par_q,         par_d;
  logic             par_bad_q,     par_bad_d;
  logic             bit8_q,        bit8_d;
  logic             par_en_q,      par_en_d;
  logic             odd_q,         odd_d;
  logic [7:0]       rx_byte_q,     rx_byte_d;
  logic             rx_rdy_q,      rx_rdy_d;
  logic             parity_err_q,  parity_err_d;
  logic             framing_err_q, framing_err_d;
  logic             overflow_q,    overflow_d;
  logic             commit;
  logic             centre;

  assign centre = baud_pulse && (samp_cnt_q == CNT_LAST);

  always_comb begin
    state_d       = state_q;
    samp_cnt_d    = samp_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    par_d         = par_q;
    par_bad_d     = par_bad_q;
    bit8_d        = bit8_q;
    par_en_d      = par_en_q;
    odd_d         = odd_q;
    rx_byte_d     = rx_byte_q;
    rx_rdy_d      = rx_rdy_q;
    parity_err_d  = parity_err_q;
    framing_err_d = framing_err_q;
    overflow_d    = overflow_q;
    commit        = 1'b0;

    case (state_q)
      RX_IDLE: begin
        if (baud_pulse && !rx_s) begin
          state_d    = RX_START;
          samp_cnt_d = '0;
        end
      end
      RX_START: begin
        if (baud_pulse) begin
          if (samp_cnt_q == CNT_HALF) begin
            samp_cnt_d = '0;
            if (samp) begin
              state_d = RX_IDLE;
            end else begin
              state_d   = RX_DATA;
              bit_cnt_d = '0;
              shift_d   = '0;
              par_d     = 1'b0;
              par_bad_d = 1'b0;
              bit8_d    = bit8;
              par_en_d  = parity_en;
              odd_d     = odd_n_even;
            end
          end else begin
            samp_cnt_d = samp_cnt_q + CNT_W'(1);
          end
        end
      end
      RX_DATA: begin
        if (centre) begin
          samp_cnt_d         = '0;
          shift_d[bit_cnt_q] = samp;
          par_d              = par_q ^ samp;
          if (bit_cnt_q == (bit8_q ? 3'd7 : 3'd6)) begin
            state_d = par_en_q ? RX_PARITY : RX_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else if (baud_pulse) begin
          samp_cnt_d = samp_cnt_q + CNT_W'(1);
        end
      end
      RX_PARITY: begin
        if (centre) begin
          samp_cnt_d = '0;
          par_bad_d  = samp ^ par_q ^ odd_q;
          state_d    = RX_STOP;
        end else if (baud_pulse) begin
          samp_cnt_d = samp_cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (centre) begin
          samp_cnt_d = '0;
          commit     = 1'b1;
          state_d    = samp ? RX_IDLE : RX_BREAK;
        end else if (baud_pulse) begin
          samp_cnt_d = samp_cnt_q + CNT_W'(1);
        end
      end
      RX_BREAK: begin
        // Hold off start detection until the line returns to idle.
        if (baud_pulse && rx_s) begin
          state_d = RX_IDLE;
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase

    if (commit) begin
      if (!rx_rdy_q || read_rx_byte) begin
        rx_byte_d     = shift_q;
        parity_err_d  = par_bad_q & par_en_q;
        framing_err_d = ~samp;
        rx_rdy_d      = 1'b1;
        overflow_d    = 1'b0;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (read_rx_byte && rx_rdy_q) begin
      rx_rdy_d      = 1'b0;
      parity_err_d  = 1'b0;
      framing_err_d = 1'b0;
      overflow_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RX_IDLE;
      samp_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      par_q         <= 1'b0;
      par_bad_q     <= 1'b0;
      bit8_q        <= 1'b0;
      par_en_q      <= 1'b0;
      odd_q         <= 1'b0;
      rx_byte_q     <= '0;
      rx_rdy_q      <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      samp_cnt_q    <= samp_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      par_bad_q     <= par_bad_d;
      bit8_q        <= bit8_d;
      par_en_q      <= par_en_d;
      odd_q         <= odd_d;
      rx_byte_q     <= rx_byte_d;
      rx_rdy_q      <= rx_rdy_d;
      parity_err_q  <= parity_err_d;
      framing_err_q <= framing_err_d;
      overflow_q    <= overflow_d;
    end
  end

  assign rx_byte     = rx_byte_q;
  assign rx_rdy      = rx_rdy_q;
  assign parity_err  = parity_err_q;
  assign framing_err = framing_err_q;
  assign overflow    = overflow_q;

endmodule
`default_nettype wire
